// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the sequential multiply/divide unit.
// Latency: n/a (definitions only).
// Backpressure: n/a; FS codes are shared with the combinational ALU decode.
package muldiv_pkg;

  localparam logic [4:0] FS_MULT = 5'h1E;
  localparam logic [4:0] FS_DIV  = 5'h1F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_abs.sv
// Combinational two's complement conditional negate (magnitude or sign restore).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
module muldiv_abs
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed WIDTHxWIDTH multiply / WIDTH/WIDTH divide owning HI/LO (macro MULDIV_EARLY_OUT_EN enables MUL early-out).
// Latency: WIDTH+1 cycles from the accepting edge to done; DIV by zero flags done on the accepting edge.
// Backpressure: busy high while iterating; start is ignored unless IDLE, so the control unit must stall on busy.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       FS,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 op_div;
  logic                 sign_q;   // product / quotient sign
  logic                 sign_r;   // remainder sign (follows dividend)
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     quot;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     rem;

  logic [WIDTH-1:0]     s_mag;
  logic [WIDTH-1:0]     t_mag;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;

  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH:0]       shifted;
  logic                 ge;
  logic [WIDTH-1:0]     rem_nxt;
  logic                 mul_stop;

  // Operand magnitudes; -2^(WIDTH-1) becomes unsigned 2^(WIDTH-1).
  muldiv_abs #(.W(WIDTH)) u_abs_s (.val(S), .neg(S[WIDTH-1]), .res(s_mag));
  muldiv_abs #(.W(WIDTH)) u_abs_t (.val(T), .neg(T[WIDTH-1]), .res(t_mag));

  // Sign restoration applied in FIX.
  muldiv_abs #(.W(2*WIDTH)) u_fix_prod (.val(acc),  .neg(sign_q), .res(prod_fix));
  muldiv_abs #(.W(WIDTH))   u_fix_quot (.val(quot), .neg(sign_q), .res(quot_fix));
  muldiv_abs #(.W(WIDTH))   u_fix_rem  (.val(rem),  .neg(sign_r), .res(rem_fix));

  // One shift-add step and one restoring-division step, evaluated every cycle.
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    shifted = {rem, quot[WIDTH-1]};
    ge      = (shifted >= {1'b0, divisor});
    // When ge holds the true difference is below divisor, so WIDTH bits suffice.
    rem_nxt = ge ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
`ifdef MULDIV_EARLY_OUT_EN
    mul_stop = (mplier == '0);
`else
    mul_stop = 1'b0;
`endif
  end

  // Control FSM with registered outputs and iteration datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_div      <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      mcand       <= '0;
      acc         <= '0;
      mplier      <= '0;
      quot        <= '0;
      divisor     <= '0;
      rem         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && FS == FS_MULT) begin
            mcand       <= {{WIDTH{1'b0}}, s_mag};
            mplier      <= t_mag;
            acc         <= '0;
            sign_q      <= S[WIDTH-1] ^ T[WIDTH-1];
            op_div      <= 1'b0;
            cnt         <= CW'(WIDTH - 1);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= MUL;
          end else if (start && FS == FS_DIV) begin
            if (T == '0) begin
              // Flag immediately and leave HI/LO untouched.
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              quot        <= s_mag;
              divisor     <= t_mag;
              rem         <= '0;
              sign_q      <= S[WIDTH-1] ^ T[WIDTH-1];
              sign_r      <= S[WIDTH-1];
              op_div      <= 1'b1;
              cnt         <= CW'(WIDTH - 1);
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
              state       <= DIV;
            end
          end
        end
        MUL: begin
          if (mul_stop) begin
            state <= FIX;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == '0) state <= FIX;
          end
        end
        DIV: begin
          rem  <= rem_nxt;
          quot <= {quot[WIDTH-2:0], ge};
          cnt  <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (op_div) begin
            HI <= rem_fix;
            LO <= quot_fix;
          end else begin
            HI <= prod_fix[2*WIDTH-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table of signed MULT/DIV cases plus hand sequences.
// Latency: checks done edge count relative to the accepting edge.
// Backpressure: exercises start while busy, ignored FS codes and mid-operation reset.
module tb_muldiv_seq;

  localparam logic [4:0] F_MULT = 5'h1E;
  localparam logic [4:0] F_DIV  = 5'h1F;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  FS = 5'h00;
  logic [31:0] S = '0;
  logic [31:0] T = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [4:0]  fs;
    logic [31:0] s;
    logic [31:0] t;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[14];

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .FS(FS), .S(S), .T(T),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected MULT latency: fixed, or early-out after the last set multiplier bit.
  function automatic int mul_lat(input logic [31:0] t);
    logic [31:0] m;
    int n;
    if (!EARLY) return 33;
    m = t[31] ? (~t + 32'd1) : t;
    n = 0;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return (n == 32) ? 33 : n + 2;
  endfunction

  // Issue one request and return the done edge index relative to the accepting edge (-1 on timeout).
  task automatic run_op(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t,
                        output int lat, output logic busy_e0, output logic busy_gap);
    @(negedge clk);
    start = 1'b1; FS = fs; S = s; T = t;
    @(posedge clk); #1;
    start = 1'b0; S = $urandom; T = $urandom;
    busy_e0 = busy; busy_gap = 1'b0; lat = -1;
    if (done) lat = 0;
    else begin
      for (int k = 1; k <= 100; k++) begin
        @(posedge clk); #1;
        if (done) begin lat = k; break; end
        if (!busy) busy_gap = 1'b1;
      end
    end
  endtask

  initial begin
    int lat, exp_lat;
    logic be0, gap, seen;
    logic [31:0] hi_prev, lo_prev;

    vecs[0]  = '{F_MULT, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{F_MULT, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{F_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{F_DIV,  32'd100,        32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
    vecs[4]  = '{F_MULT, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6]  = '{F_DIV,  32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[7]  = '{F_MULT, 32'h1234_5678,  32'h10,        32'h0000_0001, 32'h2345_6780, 1'b0};
    vecs[8]  = '{F_DIV,  32'h7FFF_FFFF,  32'd1,         32'h0000_0000, 32'h7FFF_FFFF, 1'b0};
    vecs[9]  = '{F_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[10] = '{F_DIV,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0};
    vecs[11] = '{F_DIV,  32'd5,          32'd10,        32'h0000_0005, 32'h0000_0000, 1'b0};
    vecs[12] = '{F_MULT, 32'd5,          32'd0,         32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[13] = '{F_DIV,  32'd3,          32'd0,         32'h0000_0000, 32'h0000_0000, 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven operations.
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].fs, vecs[i].s, vecs[i].t, lat, be0, gap);
      if (vecs[i].fs == F_DIV) exp_lat = (vecs[i].t == 32'd0) ? 0 : 33;
      else exp_lat = mul_lat(vecs[i].t);
      chk($sformatf("v%0d_lat", i), lat, exp_lat);
      chk($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      chk($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
      chk($sformatf("v%0d_busy_e0", i), {31'd0, be0}, (exp_lat != 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_busy_gap", i), {31'd0, gap}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
    end

    // Unrecognised FS code is ignored.
    hi_prev = HI; lo_prev = LO;
    @(negedge clk);
    start = 1'b1; FS = 5'h05; S = 32'd9; T = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("ign_done", {31'd0, done}, 32'd0);
    chk("ign_hi", HI, hi_prev);
    chk("ign_lo", LO, lo_prev);

    // Start while busy and operand changes after acceptance have no effect.
    @(negedge clk);
    start = 1'b1; FS = F_MULT; S = 32'd6; T = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; S = 32'hDEAD_BEEF; T = 32'h0000_0003;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    @(negedge clk);
    start = 1'b1; FS = F_DIV; S = 32'd100; T = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    if (done) seen = 1'b1;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("busy_start_done", {31'd0, seen}, 32'd1);
    chk("busy_start_hi", HI, 32'd0);
    chk("busy_start_lo", LO, 32'd42);
    @(posedge clk); #1;
    chk("busy_start_no_div", {31'd0, busy}, 32'd0);

    // Reset asserted at E10 of a fresh MULT aborts it.
    @(negedge clk);
    start = 1'b1; FS = F_MULT; S = 32'd3; T = 32'h4000_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
